char_line_sched: RTL

- Schedules one shared 8x8 glyph renderer across a row of up to 16 characters on the VGA display.
- Holds a double-buffered message: a shadow buffer that the CPU/debug side writes, and an active buffer that is scanned.
- On each scanline it steps the renderer's char_add / x_pos through the active slots at an 8-pixel pitch.
- Committed messages swap into the active buffer only at a frame boundary, so there is no tearing.

---
 rtl/char_line_sched_pkg.sv | 33 +++
 rtl/char_line_sched_char_buf_2x.sv | 51 +++++
 rtl/char_line_sched.sv | 127 ++++++++++++
 3 files changed

// File: rtl/char_line_sched_pkg.sv
// rtl/char_line_sched_pkg.sv - glyph codes, VGA timing constants and shared types for the text-row scheduler
package char_line_sched_pkg;

  localparam int GLYPH_W = 8;

  localparam logic [3:0] G_COMMA = 4'h0;
  localparam logic [3:0] G_A     = 4'h1;
  localparam logic [3:0] G_E     = 4'h2;
  localparam logic [3:0] G_I     = 4'h3;
  localparam logic [3:0] G_N     = 4'h4;
  localparam logic [3:0] G_O     = 4'h5;
  localparam logic [3:0] G_R     = 4'h6;
  localparam logic [3:0] G_S     = 4'h7;
  localparam logic [3:0] G_U     = 4'h8;
  localparam logic [3:0] G_W     = 4'h9;
  localparam logic [3:0] G_Y     = 4'hA;
  localparam logic [3:0] G_COLON = 4'hB;
  localparam logic [3:0] G_BLANK = 4'hF;

  localparam logic [10:0] H_ACTIVE   = 11'd800;
  localparam logic [9:0]  V_ACTIVE   = 10'd600;
  localparam logic [9:0]  SWAP_Y_DEF = 10'd600;

  typedef enum logic {
    ST_IDLE,
    ST_PENDING
  } commit_state_e;

  function automatic logic [10:0] next_x(input logic [10:0] x);
    return x + 11'(GLYPH_W);
  endfunction

endpackage

// File: rtl/char_line_sched_char_buf_2x.sv
// rtl/char_line_sched_char_buf_2x.sv - shadow/active glyph buffer pair with atomic copy and length-masked read
module char_buf_2x
  import char_line_sched_pkg::*;
#(
  parameter int         N_CHARS    = 16,
  parameter logic [3:0] BLANK_CODE = G_BLANK
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en_i,
  input  logic [3:0] wr_addr_i,
  input  logic [3:0] wr_data_i,
  input  logic       copy_i,
  input  logic [4:0] len_i,
  input  logic [4:0] rd_idx_i,
  output logic [3:0] code_o
);

  logic [3:0] shadow_q [0:15];
  logic [3:0] active_q [0:15];
  logic [4:0] active_len_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        shadow_q[i] <= BLANK_CODE;
        active_q[i] <= BLANK_CODE;
      end
      active_len_q <= 5'd0;
    end else begin
      if (copy_i) begin
        for (int i = 0; i < 16; i++) begin
          active_q[i] <= shadow_q[i];
        end
        active_len_q <= len_i;
      end
      if (wr_en_i && ({1'b0, wr_addr_i} < 5'(N_CHARS))) begin
        shadow_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  // Slots past the committed length read as blank so stale glyphs never render.
  always_comb begin
    code_o = BLANK_CODE;
    if ((rd_idx_i < active_len_q) && (rd_idx_i < 5'(N_CHARS))) begin
      code_o = active_q[rd_idx_i[3:0]];
    end
  end

endmodule

// File: rtl/char_line_sched.sv
// rtl/char_line_sched.sv - steps one shared glyph renderer across a double-buffered row of characters
module char_line_sched
  import char_line_sched_pkg::*;
#(
  parameter int          N_CHARS    = 16,
  parameter logic [10:0] X_BASE     = 11'd100,
  parameter logic [9:0]  Y_BASE     = 10'd20,
  parameter logic [9:0]  SWAP_Y     = SWAP_Y_DEF,
  parameter logic [3:0]  BLANK_CODE = G_BLANK
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x_count,
  input  logic [9:0]  y_count,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [3:0]  wr_data,
  input  logic [4:0]  len_in,
  input  logic        commit,
  output logic        commit_ack,
  output logic        pending,
  output logic [3:0]  char_add,
  output logic [10:0] x_pos,
  output logic [9:0]  y_pos,
  output logic        line_active
);

  commit_state_e state_q;
  logic [4:0]    len_q;
  logic          ack_q;
  logic [4:0]    slot_q, slot_d;
  logic [10:0]   x_pos_q, x_pos_d;
  logic [3:0]    char_add_q, char_add_d;
  logic          line_active_q, line_active_d;

  logic       line_start;
  logic       step;
  logic       swap;
  logic       wr_ok;
  logic [4:0] rd_idx;
  logic [3:0] code;

  assign line_start = (x_count == 11'd0);
  assign swap       = line_start && (y_count == SWAP_Y) && (state_q == ST_PENDING);
  assign wr_ok      = wr_en && (state_q == ST_IDLE);
  assign step       = !line_start && (x_count == x_pos_q) && (slot_q < 5'(N_CHARS));
  assign rd_idx     = line_start ? 5'd0 : slot_q + 5'd1;

  char_buf_2x #(
    .N_CHARS   (N_CHARS),
    .BLANK_CODE(BLANK_CODE)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .wr_en_i  (wr_ok),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .copy_i   (swap),
    .len_i    (len_q),
    .rd_idx_i (rd_idx),
    .code_o   (code)
  );

  // Commit handshake: the swap is evaluated against the registered state, so a
  // commit landing on the boundary cycle waits a full frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= 5'd0;
      ack_q   <= 1'b0;
    end else begin
      ack_q <= swap;
      case (state_q)
        ST_IDLE: begin
          if (commit && (len_in <= 5'(N_CHARS))) begin
            len_q   <= len_in;
            state_q <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (swap) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    slot_d        = slot_q;
    x_pos_d       = x_pos_q;
    char_add_d    = char_add_q;
    line_active_d = (y_count >= Y_BASE) && (y_count <= Y_BASE + 10'd7);
    if (line_start) begin
      slot_d     = 5'd0;
      x_pos_d    = X_BASE;
      char_add_d = code;
    end else if (step) begin
      slot_d     = slot_q + 5'd1;
      x_pos_d    = next_x(x_pos_q);
      char_add_d = code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q        <= 5'd0;
      x_pos_q       <= X_BASE;
      char_add_q    <= BLANK_CODE;
      line_active_q <= 1'b0;
    end else begin
      slot_q        <= slot_d;
      x_pos_q       <= x_pos_d;
      char_add_q    <= char_add_d;
      line_active_q <= line_active_d;
    end
  end

  assign commit_ack  = ack_q;
  assign pending     = (state_q == ST_PENDING);
  assign char_add    = char_add_q;
  assign x_pos       = x_pos_q;
  assign y_pos       = Y_BASE;
  assign line_active = line_active_q;

endmodule
